// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - 256-bit cache-line to 4x64-bit memory burst adaptor
// Optional build macro: CACHELINE_ADAPTOR_ALIGN_EN forces address_o[4:0] to zero.
module cacheline_adaptor #(
   parameter int LINE_WIDTH  = 256,
   parameter int BURST_WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [LINE_WIDTH-1:0]  line_i,
   output logic [LINE_WIDTH-1:0]  line_o,
   input  logic [31:0]            address_i,
   input  logic                   read_i,
   input  logic                   write_i,
   output logic                   resp_o,
   input  logic [BURST_WIDTH-1:0] burst_i,
   output logic [BURST_WIDTH-1:0] burst_o,
   output logic [31:0]            address_o,
   output logic                   read_o,
   output logic                   write_o,
   input  logic                   resp_i
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t                state;
   state_t                state_next;
   logic [1:0]            beat;
   logic [31:0]           addr_q;
   logic [LINE_WIDTH-1:0] line_q;
   logic                  last_beat;

   assign last_beat = resp_i && (beat == 2'd3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Read has priority; a write held alongside it is picked up on the next IDLE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (read_i) begin
               state_next = READ;
            end else if (write_i) begin
               state_next = WRITE;
            end
         end
         READ:    if (last_beat) state_next = DONE;
         WRITE:   if (last_beat) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      read_o  = (state == READ);
      write_o = (state == WRITE);
      resp_o  = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat   <= 2'd0;
         addr_q <= 32'd0;
         line_q <= '0;
         line_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (read_i || write_i) begin
                  addr_q <= address_i;
                  beat   <= 2'd0;
                  if (!read_i) begin
                     line_q <= line_i;
                  end
               end
            end
            READ: begin
               if (resp_i) begin
                  line_o[int'(beat) * BURST_WIDTH +: BURST_WIDTH] <= burst_i;
                  beat <= beat + 2'd1;
               end
            end
            WRITE: begin
               if (resp_i) begin
                  beat <= beat + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign burst_o = line_q[int'(beat) * BURST_WIDTH +: BURST_WIDTH];

`ifdef CACHELINE_ADAPTOR_ALIGN_EN
   assign address_o = {addr_q[31:5], 5'b0};
`else
   assign address_o = addr_q;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - self-checking bench for cacheline_adaptor
// Reference model: expected line is the concatenation of returned beats; expected write beat is line slice by handshake count.
module tb_cacheline_adaptor;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [255:0] line_i;
   logic [255:0] line_o;
   logic [31:0]  address_i;
   logic         read_i;
   logic         write_i;
   logic         resp_o;
   logic [63:0]  burst_i;
   logic [63:0]  burst_o;
   logic [31:0]  address_o;
   logic         read_o;
   logic         write_o;
   logic         resp_i;

   int checks = 0;
   int failures = 0;
   logic [255:0] model_line;

   cacheline_adaptor dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .line_i    (line_i),
      .line_o    (line_o),
      .address_i (address_i),
      .read_i    (read_i),
      .write_i   (write_i),
      .resp_o    (resp_o),
      .burst_i   (burst_i),
      .burst_o   (burst_o),
      .address_o (address_o),
      .read_o    (read_o),
      .write_o   (write_o),
      .resp_i    (resp_i)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] exp_addr(input logic [31:0] a);
`ifdef CACHELINE_ADAPTOR_ALIGN_EN
      return {a[31:5], 5'b0};
`else
      return a;
`endif
   endfunction

   function automatic logic [255:0] rand_line();
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   // Presents a request, lets one edge accept it, then scrambles the request inputs.
   task automatic start_req(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [255:0] line, input bit keep_rd, input bit keep_wr);
      read_i    = rd;
      write_i   = wr;
      address_i = addr;
      line_i    = line;
      @(posedge clk); #1;
      if (!keep_rd) read_i = 1'b0;
      if (!keep_wr) write_i = 1'b0;
      address_i = $urandom;
      line_i    = rand_line();
   endtask

   // Runs one burst from its first active cycle through the DONE cycle and the following IDLE cycle.
   task automatic run_burst(input bit is_rd, input logic [31:0] addr, input logic [255:0] data,
                            input int stall_pct, input int stall_at, input int stall_n,
                            input string tag, output int cycles);
      int hs = 0;
      int cyc = 0;
      int stalled = 0;
      logic [255:0] d;
      d = data;
      while (hs < 4 && cyc < 100) begin
         checks++;
         if (read_o !== is_rd || write_o !== !is_rd || resp_o !== 1'b0) begin
            failures++;
            $display("FAIL %s_req_flags cyc=%0d got rd=%b wr=%b resp=%b want rd=%b wr=%b resp=0",
                     tag, cyc, read_o, write_o, resp_o, is_rd, !is_rd);
         end
         checks++;
         if (address_o !== exp_addr(addr)) begin
            failures++;
            $display("FAIL %s_address got=%h want=%h", tag, address_o, exp_addr(addr));
         end
         if (!is_rd) begin
            checks++;
            if (burst_o !== d[hs*64 +: 64]) begin
               failures++;
               $display("FAIL %s_burst_o beat=%0d got=%h want=%h", tag, hs, burst_o, d[hs*64 +: 64]);
            end
         end
         if (hs == stall_at && stalled < stall_n) begin
            resp_i = 1'b0;
            stalled++;
         end else begin
            resp_i = ($urandom_range(99) >= stall_pct);
         end
         burst_i = resp_i ? d[hs*64 +: 64] : {$urandom, $urandom};
         @(posedge clk); #1;
         if (resp_i) hs++;
         cyc++;
      end
      resp_i = 1'b0;
      checks++;
      if (hs < 4) begin
         failures++;
         $display("FAIL %s_timeout handshakes got=%0d want=4", tag, hs);
      end
      if (is_rd) model_line = data;
      checks++;
      if (resp_o !== 1'b1 || read_o !== 1'b0 || write_o !== 1'b0) begin
         failures++;
         $display("FAIL %s_done got resp=%b rd=%b wr=%b want resp=1 rd=0 wr=0", tag, resp_o, read_o, write_o);
      end
      checks++;
      if (line_o !== model_line) begin
         failures++;
         $display("FAIL %s_line_o got=%h want=%h", tag, line_o, model_line);
      end
      @(posedge clk); #1;
      checks++;
      if ({read_o, write_o, resp_o} !== 3'b000) begin
         failures++;
         $display("FAIL %s_after_done got rd=%b wr=%b resp=%b want 000", tag, read_o, write_o, resp_o);
      end
      checks++;
      if (line_o !== model_line) begin
         failures++;
         $display("FAIL %s_line_hold got=%h want=%h", tag, line_o, model_line);
      end
      cycles = cyc;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
      line_i = '0; address_i = '0; burst_i = '0;
      model_line = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({read_o, write_o, resp_o} !== 3'b000 || address_o !== 32'd0 || burst_o !== 64'd0 || line_o !== 256'd0) begin
         failures++;
         $display("FAIL reset_outputs got rd=%b wr=%b resp=%b addr=%h burst=%h line=%h want all zero",
                  read_o, write_o, resp_o, address_o, burst_o, line_o);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({read_o, write_o, resp_o} !== 3'b000) begin
         failures++;
         $display("FAIL reset_idle got rd=%b wr=%b resp=%b want 000", read_o, write_o, resp_o);
      end
   endtask

   task automatic test_read_directed();
      int cyc;
      logic [255:0] d;
      d = {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}};
      start_req(1'b1, 1'b0, 32'h0000_1040, '0, 1'b0, 1'b0);
      run_burst(1'b1, 32'h0000_1040, d, 0, -1, 0, "read_directed", cyc);
      checks++;
      if (cyc !== 4) begin
         failures++;
         $display("FAIL read_latency burst_cycles got=%0d want=4", cyc);
      end
   endtask

   task automatic test_write_stall();
      int cyc;
      logic [255:0] d;
      d = rand_line();
      start_req(1'b0, 1'b1, 32'h0000_2000, d, 1'b0, 1'b0);
      run_burst(1'b0, 32'h0000_2000, d, 0, 1, 2, "write_stall", cyc);
      checks++;
      if (cyc !== 6) begin
         failures++;
         $display("FAIL write_stall_cycles got=%0d want=6", cyc);
      end
   endtask

   task automatic test_both_requests();
      int cyc;
      logic [255:0] rd_data;
      logic [255:0] wr_line;
      rd_data = rand_line();
      wr_line = rand_line();
      start_req(1'b1, 1'b1, 32'h0000_3000, wr_line, 1'b0, 1'b1);
      run_burst(1'b1, 32'h0000_3000, rd_data, 20, -1, 0, "both_read", cyc);
      start_req(1'b0, 1'b1, 32'h0000_3100, wr_line, 1'b0, 1'b0);
      run_burst(1'b0, 32'h0000_3100, wr_line, 20, -1, 0, "both_write", cyc);
   endtask

   task automatic test_align();
      int cyc;
      logic [31:0] want;
`ifdef CACHELINE_ADAPTOR_ALIGN_EN
      want = 32'h0000_1040;
`else
      want = 32'h0000_1047;
`endif
      start_req(1'b1, 1'b0, 32'h0000_1047, '0, 1'b0, 1'b0);
      checks++;
      if (address_o !== want) begin
         failures++;
         $display("FAIL align_address got=%h want=%h", address_o, want);
      end
      run_burst(1'b1, 32'h0000_1047, rand_line(), 0, -1, 0, "align", cyc);
   endtask

   task automatic test_stray_resp();
      int cyc;
      for (int i = 0; i < 2; i++) begin
         resp_i = 1'b1;
         @(posedge clk); #1;
         checks++;
         if ({read_o, write_o, resp_o} !== 3'b000 || line_o !== model_line) begin
            failures++;
            $display("FAIL stray_resp got rd=%b wr=%b resp=%b line=%h want idle line=%h",
                     read_o, write_o, resp_o, line_o, model_line);
         end
      end
      resp_i = 1'b0;
      start_req(1'b1, 1'b0, 32'h0000_4000, '0, 1'b1, 1'b0);
      run_burst(1'b1, 32'h0000_4000, rand_line(), 0, -1, 0, "held_first", cyc);
      address_i = 32'h0000_4000;
      @(posedge clk); #1;
      read_i = 1'b0;
      run_burst(1'b1, 32'h0000_4000, rand_line(), 0, -1, 0, "held_second", cyc);
   endtask

   task automatic test_reset_mid_burst();
      start_req(1'b1, 1'b0, 32'h0000_5000, '0, 1'b0, 1'b0);
      resp_i = 1'b1;
      burst_i = {$urandom, $urandom};
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (read_o !== 1'b0 || line_o !== 256'd0) begin
         failures++;
         $display("FAIL reset_mid_async got rd=%b line=%h want rd=0 line=0", read_o, line_o);
      end
      resp_i = 1'b0;
      model_line = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({read_o, write_o, resp_o} !== 3'b000) begin
            failures++;
            $display("FAIL reset_mid_no_resp got rd=%b wr=%b resp=%b want 000", read_o, write_o, resp_o);
         end
      end
   endtask

   task automatic test_random();
      int cyc;
      bit rd;
      logic [31:0] a;
      logic [255:0] d;
      for (int n = 0; n < 16; n++) begin
         rd = $urandom_range(1);
         a  = $urandom;
         d  = rand_line();
         start_req(rd, !rd, a, d, 1'b0, 1'b0);
         run_burst(rd, a, d, $urandom_range(40), -1, 0, rd ? "rand_read" : "rand_write", cyc);
      end
   endtask

   initial begin
      test_reset();
      test_read_directed();
      test_write_stall();
      test_both_requests();
      test_align();
      test_stray_resp();
      test_reset_mid_burst();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
